// File: rtl/sha256_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sha256_digest_serializer
// Purpose  : Captures a hash digest and streams it out one byte per
//            valid/ready handshake, dropping digests that arrive while busy.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_digest_serializer #(
    parameter int DIGEST_W  = 256,
    parameter int BYTE_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int NBYTES   = DIGEST_W / BYTE_W,
    localparam int IDX_W    = $clog2(NBYTES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [DIGEST_W-1:0] digest_i,
    input  logic                digest_vld_i,
    input  logic                overflow_i,
    output logic [BYTE_W-1:0]   data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic [IDX_W-1:0]    byte_idx_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                drop_o
);

    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_SEND     = 1'b1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NBYTES - 1);

    logic [0:0]          r_state;
    logic [DIGEST_W-1:0] r_shift;
    logic [IDX_W-1:0]    r_idx;
    logic                r_done;
    logic                r_drop;

    logic                w_send;
    logic                w_last;
    logic                w_hs;
    logic                w_final;
    logic                w_accept;
    logic [BYTE_W-1:0]   w_head;
    logic [DIGEST_W-1:0] w_shift_next;

    // The head of the shift register is always the byte on data_o.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head       = r_shift[DIGEST_W-1 -: BYTE_W];
            assign w_shift_next = r_shift << BYTE_W;
        end else begin : g_lsb_first
            assign w_head       = r_shift[BYTE_W-1:0];
            assign w_shift_next = r_shift >> BYTE_W;
        end
    endgenerate

    assign w_send  = (r_state == c_SEND);
    assign w_last  = w_send && (r_idx == c_LAST_IDX);
    assign w_hs    = w_send && ready_i;
    assign w_final = w_last && ready_i;

    // A new digest is taken when idle, or seamlessly on the final handshake.
    assign w_accept = digest_vld_i && !overflow_i && (!w_send || w_final);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_done <= w_final;
            r_drop <= digest_vld_i && !w_accept;
            if (w_accept) begin
                r_state <= c_SEND;
                r_shift <= digest_i;
                r_idx   <= '0;
            end else if (w_final) begin
                r_state <= c_IDLE;
                r_idx   <= '0;
            end else if (w_hs) begin
                r_shift <= w_shift_next;
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    assign data_o     = w_head;
    assign valid_o    = w_send;
    assign last_o     = w_last;
    assign byte_idx_o = r_idx;
    assign busy_o     = w_send;
    assign done_o     = r_done;
    assign drop_o     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sha256_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_digest_serializer
// Purpose  : Directed self-checking bench for sha256_digest_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_digest_serializer;

    localparam logic [255:0] c_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk_i;
    logic         rst_ni;
    logic [255:0] digest_i;
    logic         digest_vld_i;
    logic         overflow_i;
    logic [7:0]   data_o;
    logic         valid_o;
    logic         ready_i;
    logic         last_o;
    logic [4:0]   byte_idx_o;
    logic         busy_o;
    logic         done_o;
    logic         drop_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_bytes [32];

    typedef struct {
        logic         vld;
        logic         ovf;
        logic         rdy;
        logic [255:0] dig;
        logic         e_valid;
        logic         e_busy;
        logic [7:0]   e_data;
        logic [4:0]   e_idx;
        logic         e_drop;
        logic         e_done;
    } vec_t;

    vec_t tbl [10];

    sha256_digest_serializer #(
        .DIGEST_W  (256),
        .BYTE_W    (8),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .digest_i     (digest_i),
        .digest_vld_i (digest_vld_i),
        .overflow_i   (overflow_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .last_o       (last_o),
        .byte_idx_o   (byte_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .drop_o       (drop_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [255:0] d, input int k);
        return d[255 - 8*k -: 8];
    endfunction

    task automatic start(input logic [255:0] dig);
        digest_i     = dig;
        overflow_i   = 1'b0;
        digest_vld_i = 1'b1;
        @(negedge clk_i);
        digest_vld_i = 1'b0;
    endtask

    // Walks one stream from byte 0, checking every cycle; optionally injects a
    // busy-time digest at byte drop_at and a back-to-back digest on the last byte.
    task automatic collect(input logic [255:0] dig, input int ready_pct, input int drop_at,
                           input bit b2b, input logic [255:0] next_dig, input bit done_first);
        int k = 0;
        int cyc = 0;
        bit drop_pend = 1'b0;
        bit dropped = 1'b0;
        while (k < 32 && cyc < 1000) begin
            chk($sformatf("stream valid c%0d", cyc), valid_o, 1'b1);
            chk($sformatf("stream busy c%0d", cyc), busy_o, 1'b1);
            chk($sformatf("stream data k%0d", k), data_o, exp_byte(dig, k));
            chk($sformatf("stream idx k%0d", k), byte_idx_o, k);
            chk($sformatf("stream last k%0d", k), last_o, (k == 31));
            chk($sformatf("stream done c%0d", cyc), done_o, (cyc == 0) ? done_first : 1'b0);
            chk($sformatf("stream drop c%0d", cyc), drop_o, drop_pend);
            drop_pend    = 1'b0;
            digest_vld_i = 1'b0;
            overflow_i   = 1'b0;
            if (k == drop_at && !dropped) begin
                digest_i     = '0;
                digest_vld_i = 1'b1;
                dropped      = 1'b1;
                drop_pend    = 1'b1;
            end
            ready_i = ($urandom_range(0, 99) < ready_pct);
            if (b2b && k == 31 && ready_i) begin
                digest_i     = next_dig;
                digest_vld_i = 1'b1;
            end
            if (ready_i) begin
                got_bytes[k] = data_o;
                k++;
            end
            @(negedge clk_i);
            cyc++;
        end
        digest_vld_i = 1'b0;
        ready_i      = 1'b0;
        chk("stream handshakes", k, 32);
        chk("stream done pulse", done_o, 1'b1);
        if (b2b) begin
            chk("b2b valid no gap", valid_o, 1'b1);
            chk("b2b first byte", data_o, exp_byte(next_dig, 0));
            chk("b2b drop", drop_o, 1'b0);
        end else begin
            chk("end valid", valid_o, 1'b0);
            chk("end busy", busy_o, 1'b0);
            chk("end idx", byte_idx_o, 0);
            chk("end last", last_o, 1'b0);
            chk("end drop", drop_o, 1'b0);
        end
    endtask

    initial begin
        rst_ni       = 1'b1;
        digest_i     = '0;
        digest_vld_i = 1'b0;
        overflow_i   = 1'b0;
        ready_i      = 1'b0;

        tbl[0] = '{1'b1, 1'b1, 1'b0, c_ABC,   1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, c_ABC,   1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, c_EMPTY, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, c_EMPTY, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, c_ABC,   1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, c_EMPTY, 1'b1, 1'b1, 8'he3, 5'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, c_ABC,   1'b1, 1'b1, 8'he3, 5'd0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, c_ABC,   1'b1, 1'b1, 8'hb0, 5'd1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, '0,      1'b1, 1'b1, 8'hc4, 5'd2, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, c_ABC,   1'b1, 1'b1, 8'hc4, 5'd2, 1'b0, 1'b0};

        // Asynchronous reset before any clock edge
        #1 rst_ni = 1'b0;
        #2;
        chk("reset valid", valid_o, 1'b0);
        chk("reset data", data_o, 8'h00);
        chk("reset idx", byte_idx_o, 0);
        chk("reset last", last_o, 1'b0);
        chk("reset busy", busy_o, 1'b0);
        chk("reset done", done_o, 1'b0);
        chk("reset drop", drop_o, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Overflow drops, ignored digest_i changes, capture, busy-time drops
        for (int i = 0; i < 10; i++) begin
            digest_vld_i = tbl[i].vld;
            overflow_i   = tbl[i].ovf;
            ready_i      = tbl[i].rdy;
            digest_i     = tbl[i].dig;
            @(negedge clk_i);
            chk($sformatf("vec%0d valid", i), valid_o, tbl[i].e_valid);
            chk($sformatf("vec%0d busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("vec%0d data", i), data_o, tbl[i].e_data);
            chk($sformatf("vec%0d idx", i), byte_idx_o, tbl[i].e_idx);
            chk($sformatf("vec%0d last", i), last_o, 1'b0);
            chk($sformatf("vec%0d drop", i), drop_o, tbl[i].e_drop);
            chk($sformatf("vec%0d done", i), done_o, tbl[i].e_done);
        end
        digest_vld_i = 1'b0;
        overflow_i   = 1'b0;

        // Advance to byte 5, then reset mid-stream
        ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("pre-reset idx", byte_idx_o, 5);
        chk("pre-reset data", data_o, 8'hfc);
        rst_ni = 1'b0;
        #1;
        chk("midreset valid", valid_o, 1'b0);
        chk("midreset idx", byte_idx_o, 0);
        chk("midreset busy", busy_o, 1'b0);
        chk("midreset last", last_o, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk($sformatf("postreset done c%0d", i), done_o, 1'b0);
            chk($sformatf("postreset valid c%0d", i), valid_o, 1'b0);
        end
        ready_i = 1'b0;

        // Basic stream, full throughput
        start(c_ABC);
        collect(c_ABC, 100, -1, 1'b0, '0, 1'b0);
        chk("basic byte0", got_bytes[0], 8'hba);
        chk("basic byte1", got_bytes[1], 8'h78);
        chk("basic byte2", got_bytes[2], 8'h16);
        chk("basic byte3", got_bytes[3], 8'hbf);
        chk("basic byte30", got_bytes[30], 8'h15);
        chk("basic byte31", got_bytes[31], 8'had);

        // Backpressure at ~30% ready
        start(c_ABC);
        collect(c_ABC, 30, -1, 1'b0, '0, 1'b0);

        // All-zero digest arriving at byte 10 is dropped
        start(c_ABC);
        collect(c_ABC, 100, 10, 1'b0, '0, 1'b0);

        // Back-to-back: new digest coincident with the final handshake
        start(c_ABC);
        collect(c_ABC, 100, -1, 1'b1, c_EMPTY, 1'b0);
        collect(c_EMPTY, 100, -1, 1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_digest_serializer.md
Name: sha256_digest_serializer

Overview:
- Output-side companion to the sha256_implement core: captures the 256-bit hash_val when the core signals completion.
- Streams the digest out one byte per handshake over a valid/ready byte interface, the reverse of the core's 8-bit data_in path.
- Sits between the hash core and the byte-wide host/UART link.
- Buffers one digest and drops, with an indication, any digest that arrives while the previous one is still streaming.

Parameters:
- DIGEST_W, 256, digest width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, output symbol width.
- MSB_FIRST, 1, 1 = byte 0 is digest_i[DIGEST_W-1 -: BYTE_W] (FIPS 180-4 byte order); 0 = byte 0 is digest_i[BYTE_W-1:0].
- Derived: NBYTES = DIGEST_W/BYTE_W (32); IDX_W = $clog2(NBYTES) (5).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- digest_i  in  DIGEST_W  hash value from the core.
- digest_vld_i  in  1  single-cycle pulse marking digest_i valid (core rdy_o rising edge).
- overflow_i  in  1  core overflow flag, sampled with digest_vld_i.
- data_o  out  BYTE_W  current output byte.
- valid_o  out  1  data_o valid.
- ready_i  in  1  sink accepts data_o when valid_o && ready_i.
- last_o  out  1  high with valid_o on the final byte.
- byte_idx_o  out  IDX_W  index of the byte currently on data_o.
- busy_o  out  1  high while in SEND.
- done_o  out  1  one-cycle pulse after the final byte handshake.
- drop_o  out  1  one-cycle pulse when a digest is discarded.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; data_o=0, valid_o=0, last_o=0, byte_idx_o=0, busy_o=0, done_o=0, drop_o=0; the shift register is cleared.
- Reset mid-stream: the stream is abandoned and valid_o falls immediately. No done_o is generated.
- FSM states: IDLE, SEND.
- IDLE:
  - digest_vld_i=1 and overflow_i=0: latch digest_i into the shift register, byte_idx=0, go to SEND.
  - digest_vld_i=1 and overflow_i=1: do not latch, pulse drop_o next cycle, stay in IDLE.
- Latency: a capture at edge N gives valid_o=1 with byte 0 on data_o in cycle N+1. This is registered; there is no combinational path from digest_i to data_o.
- SEND:
  - valid_o=1 continuously.
  - data_o, last_o and byte_idx_o are held stable while ready_i=0.
  - On each handshake (valid_o && ready_i): advance to the next byte and increment byte_idx. Throughput is 1 byte/cycle with ready_i held high.
  - last_o=1 exactly when byte_idx = NBYTES-1.
- Final handshake (last_o && ready_i):
  - Pulse done_o in the following cycle.
  - Return to IDLE with valid_o=0, byte_idx=0.
  - Exception: if digest_vld_i=1 and overflow_i=0 in that same cycle, the new digest is accepted and SEND continues with byte 0 of the new digest next cycle (no bubble). done_o still pulses.
- digest_vld_i during SEND, other than on the final-handshake cycle: the new digest is discarded, drop_o pulses next cycle, and the current stream is unaffected.
- byte_idx never wraps past NBYTES-1. Full stream length is exactly NBYTES handshakes.
- Byte ordering per MSB_FIRST. With MSB_FIRST=1, byte k = digest[DIGEST_W-1-k*BYTE_W -: BYTE_W].
- Changes on digest_i outside digest_vld_i cycles have no effect.

Test Plan:
- Basic stream:
  - Stimulus: reset, then pulse digest_vld_i with digest_i = SHA-256("abc") = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, ready_i=1.
  - Required: valid_o high one cycle after the pulse; bytes ba,78,16,bf,…,15,ad over 32 consecutive cycles; last_o only on 0xad (idx 31); done_o one cycle later; busy_o low afterwards.
- Backpressure:
  - Stimulus: same digest, ready_i random 30% duty.
  - Required: data_o and byte_idx_o stable whenever ready_i=0; sequence identical to the basic stream; exactly 32 handshakes.
- Drop while busy:
  - Stimulus: pulse digest_vld_i with 0x00..00 (all zero) at byte 10 of the "abc" stream.
  - Required: drop_o pulse; "abc" stream completes unaltered; no zero bytes are emitted.
- Back-to-back:
  - Stimulus: a new digest 0xe3b0c442…7852b855 (SHA-256 of "") with digest_vld_i coincident with the final handshake.
  - Required: byte 0xe3 appears the next cycle with no valid_o gap; done_o pulses; drop_o stays 0.
- Overflow:
  - Stimulus: digest_vld_i with overflow_i=1.
  - Required: drop_o pulse; valid_o stays 0; busy_o stays 0.
- Reset mid-stream:
  - Stimulus: assert rst_ni=0 at byte 5.
  - Required: valid_o=0 asynchronously; byte_idx_o=0; no done_o. A subsequent digest streams from byte 0.
